// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// round-robin request arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the downstream
// grant consumer; master is the arbiter side.
interface rr_req_arbiter_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               gnt_ready;
    logic               gnt_valid;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   ptr_o;

    modport master (
        input  req,
        input  gnt_ready,
        output gnt_valid,
        output gnt_onehot,
        output gnt_idx,
        output ptr_o
    );

    modport slave (
        output req,
        output gnt_ready,
        input  gnt_valid,
        input  gnt_onehot,
        input  gnt_idx,
        input  ptr_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests by the pointer, take the
// lowest set bit, then rotate the winner back to an absolute index.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick_onehot_c,
    output logic [IDX_W-1:0]   o_pick_idx_c,
    output logic               o_pick_any_c
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_any;

    // Bit k of w_rot is requester (ptr + k) mod NUM_REQ.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: NUM_REQ];

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sel = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    assign o_pick_idx_c    = w_sel + i_ptr;
    assign o_pick_onehot_c = w_any ? idx_to_onehot(o_pick_idx_c) : '0;
    assign o_pick_any_c    = w_any;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for NUM_REQ requesters; grant held under valid/ready,
// back-to-back grants on acceptance, pointer advances only when a grant is taken.
module rr_req_arbiter
    import rr_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    rr_req_arbiter_if.master  bus
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [NUM_REQ-1:0] r_onehot;
    logic [NUM_REQ-1:0] w_onehot_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;

    logic               w_accept;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    // The pick on an accepting cycle already sees the advanced pointer.
    assign w_accept   = (r_state == GRANT) && bus.gnt_ready;
    assign w_pick_ptr = w_accept ? (r_idx + IDX_W'(1)) : r_ptr;

    rr_pick u_pick (
        .i_req           (bus.req),
        .i_ptr           (w_pick_ptr),
        .o_pick_onehot_c (w_pick_onehot),
        .o_pick_idx_c    (w_pick_idx),
        .o_pick_any_c    (w_pick_any)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_valid_nxt  = r_valid;
        w_onehot_nxt = r_onehot;
        w_idx_nxt    = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt  = GRANT;
                    w_valid_nxt  = 1'b1;
                    w_onehot_nxt = w_pick_onehot;
                    w_idx_nxt    = w_pick_idx;
                end else begin
                    w_valid_nxt  = 1'b0;
                    w_onehot_nxt = '0;
                    w_idx_nxt    = '0;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_pick_any) begin
                        w_onehot_nxt = w_pick_onehot;
                        w_idx_nxt    = w_pick_idx;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_valid_nxt  = 1'b0;
                        w_onehot_nxt = '0;
                        w_idx_nxt    = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_valid  <= w_valid_nxt;
            r_onehot <= w_onehot_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign bus.gnt_valid  = r_valid;
    assign bus.gnt_onehot = r_onehot;
    assign bus.gnt_idx    = r_idx;
    assign bus.ptr_o      = r_ptr;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed vector table, model-driven random stream,
// async reset corners and per-cycle encoder / one-hot cross-checks.
module tb_rr_req_arbiter;
    import rr_arb_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       v;
        logic [3:0] oh;
        logic [1:0] idx;
        logic [1:0] ptr;
    } vec_t;

    localparam int unsigned NVEC = 25;

    logic clk;
    logic rst_n;
    rr_req_arbiter_if bus ();

    rr_req_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [NVEC];
    vec_t exp_q [$];

    // Reference model state
    logic       m_valid;
    logic [1:0] m_idx;
    logic [1:0] m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic v,
                                input logic [3:0] oh, input logic [1:0] idx, input logic [1:0] ptr);
        vec_t e;
        e.req = r; e.rdy = rd; e.v = v; e.oh = oh; e.idx = idx; e.ptr = ptr;
        return e;
    endfunction

    function automatic logic [1:0] enc4to2(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 2'd0;
        m_ptr   = 2'd0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rd);
        logic [1:0] j;
        if (m_valid && rd) begin
            m_ptr   = m_idx + 2'd1;
            m_valid = 1'b0;
        end
        if (!m_valid) begin
            for (int k = 0; k < 4; k++) begin
                j = m_ptr + 2'(k);
                if (!m_valid && r[j]) begin
                    m_valid = 1'b1;
                    m_idx   = j;
                end
            end
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("gnt_valid",  int'(bus.gnt_valid),  int'(e.v));
            chk("gnt_onehot", int'(bus.gnt_onehot), int'(e.oh));
            chk("gnt_idx",    int'(bus.gnt_idx),    int'(e.idx));
            chk("ptr_o",      int'(bus.ptr_o),      int'(e.ptr));
        end
    endtask

    // Drive one cycle; expectation comes from the table (use_tbl) or the model.
    task automatic step(input logic [3:0] r, input logic rd, input logic use_tbl, input vec_t tv);
        vec_t e;
        bus.req       = r;
        bus.gnt_ready = rd;
        model_step(r, rd);
        if (use_tbl) begin
            e = tv;
        end else begin
            e = mk(r, rd, m_valid, m_valid ? (4'b0001 << m_idx) : 4'b0000,
                   m_valid ? m_idx : 2'd0, m_ptr);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Per-cycle invariants and encoder cross-check
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot0",      int'($onehot0(bus.gnt_onehot)), 1);
            chk("valid_vs_oh",  int'(bus.gnt_valid), int'(|bus.gnt_onehot));
            chk("encoder_idx",  int'(enc4to2(bus.gnt_onehot)), int'(bus.gnt_idx));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t dummy;
        dummy = mk(4'b0, 1'b0, 1'b0, 4'b0, 2'd0, 2'd0);

        // Fairness, stall hold, wrap/skip, single-requester vectors
        tbl[0]  = mk(4'b1111, 1, 1, 4'b0001, 0, 0);
        tbl[1]  = mk(4'b1111, 1, 1, 4'b0010, 1, 1);
        tbl[2]  = mk(4'b1111, 1, 1, 4'b0100, 2, 2);
        tbl[3]  = mk(4'b1111, 1, 1, 4'b1000, 3, 3);
        tbl[4]  = mk(4'b1111, 1, 1, 4'b0001, 0, 0);
        tbl[5]  = mk(4'b1111, 1, 1, 4'b0010, 1, 1);
        tbl[6]  = mk(4'b1111, 1, 1, 4'b0100, 2, 2);
        tbl[7]  = mk(4'b1111, 1, 1, 4'b1000, 3, 3);
        tbl[8]  = mk(4'b0100, 1, 1, 4'b0100, 2, 0);
        tbl[9]  = mk(4'b0100, 0, 1, 4'b0100, 2, 0);
        tbl[10] = mk(4'b0100, 0, 1, 4'b0100, 2, 0);
        tbl[11] = mk(4'b0000, 0, 1, 4'b0100, 2, 0);
        tbl[12] = mk(4'b0000, 0, 1, 4'b0100, 2, 0);
        tbl[13] = mk(4'b0000, 0, 1, 4'b0100, 2, 0);
        tbl[14] = mk(4'b0000, 1, 0, 4'b0000, 0, 3);
        tbl[15] = mk(4'b0011, 0, 1, 4'b0001, 0, 3);
        tbl[16] = mk(4'b0011, 1, 1, 4'b0010, 1, 1);
        tbl[17] = mk(4'b0000, 1, 0, 4'b0000, 0, 2);
        tbl[18] = mk(4'b1000, 1, 1, 4'b1000, 3, 2);
        tbl[19] = mk(4'b1000, 1, 1, 4'b1000, 3, 0);
        tbl[20] = mk(4'b1000, 1, 1, 4'b1000, 3, 0);
        tbl[21] = mk(4'b0000, 1, 0, 4'b0000, 0, 0);
        tbl[22] = mk(4'b0010, 1, 1, 4'b0010, 1, 0);
        tbl[23] = mk(4'b0010, 1, 1, 4'b0010, 1, 2);
        tbl[24] = mk(4'b0000, 1, 0, 4'b0000, 0, 2);

        // Reset with all requesting
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.gnt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  int'(bus.gnt_valid),  0);
        chk("rst_onehot", int'(bus.gnt_onehot), 0);
        chk("rst_idx",    int'(bus.gnt_idx),    0);
        chk("rst_ptr",    int'(bus.ptr_o),      0);
        bus.req = 4'b0000;
        rst_n   = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            step(tbl[i].req, tbl[i].rdy, 1'b1, tbl[i]);
        end

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            step(4'($urandom), $urandom_range(0, 3) != 0, 1'b0, dummy);
        end

        // Mid-stream async reset
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 1'b0, dummy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  int'(bus.gnt_valid),  0);
        chk("async_rst_onehot", int'(bus.gnt_onehot), 0);
        chk("async_rst_idx",    int'(bus.gnt_idx),    0);
        chk("async_rst_ptr",    int'(bus.ptr_o),      0);
        #4;
        rst_n = 1'b1;
        model_reset();
        step(4'b1111, 1'b1, 1'b1, mk(4'b1111, 1, 1, 4'b0001, 0, 0));
        step(4'b1111, 1'b1, 1'b1, mk(4'b1111, 1, 1, 4'b0010, 1, 1));

        for (int i = 0; i < 40; i++) begin
            step(4'($urandom), $urandom_range(0, 1) != 0, 1'b0, dummy);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
